data_sram_responder: RTL

DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

---
 rtl/data_sram_responder_pkg.sv | 33 +++
 rtl/data_sram_responder_if.sv | 12 +
 rtl/data_sram_responder_sram_bank.sv | 30 +++
 rtl/data_sram_responder.sv | 115 +++++++++++
 4 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared constants and helpers for the data SRAM responder: region tag,
// register offsets, read-data source tag and the byte-merge function.
package data_sram_pkg;

    localparam logic [15:0] REGION_TAG = 16'h1faf;

    localparam logic [15:0] OFF_LED    = 16'hF000;
    localparam logic [15:0] OFF_NUM    = 16'hF010;
    localparam logic [15:0] OFF_SWITCH = 16'hF020;
    localparam logic [15:0] OFF_TIMER  = 16'hE000;
    localparam logic [15:0] OFF_SIMU   = 16'hFFEC;

    localparam logic [31:0] SIMU_FLAG  = 32'hFFFF_FFFF;

    // Which registered source currently owns rdata.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_REG  = 2'd2
    } rd_src_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  wen);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// CPU data-port bus: request strobe, byte enables, address, write data and
// the registered read data returned one cycle later.
interface data_sram_responder_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output en, output wen, output addr, output wdata, input rdata);
    modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_sram_responder_sram_bank.sv
// Single-port 2^AW x 32 data memory with per-byte write enables and a
// synchronous read-before-write output register.
module sram_bank #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [2**AW];
    logic [31:0] rdata_q;

    // NOTE: the array has no reset so it maps onto a RAM macro; non-blocking
    // assignment makes the read sample the word before this edge's write.
    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data-port responder: byte-write SRAM plus a small memory-mapped register
// block (LED, NUM, SWITCH, SIMU_FLAG, optional TIMER under `TIMER_EN`).
module data_sram_responder
    import data_sram_pkg::*;
#(
    parameter int MEM_AW   = 14,
    parameter int SWITCH_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    data_sram_responder_if.slave  bus,
    input  logic [SWITCH_W-1:0]   switch_in,
    output logic [15:0]           led,
    output logic [31:0]           num_data
);

    logic        is_reg;
    logic        reg_acc;
    logic        mem_en;
    logic [15:0] offset;
    logic [31:0] mem_rdata;
    logic [31:0] reg_rd;
    logic [1:0]  unused_addr_lsb;

    rd_src_e     src_q,       src_d;
    logic [31:0] reg_rdata_q, reg_rdata_d;
    logic [15:0] led_q,       led_d;
    logic [31:0] num_q,       num_d;

    assign is_reg          = (bus.addr[31:16] == REGION_TAG);
    assign offset          = bus.addr[15:0];
    assign reg_acc         = bus.en && is_reg;
    assign mem_en          = bus.en && !is_reg && !rst;
    assign unused_addr_lsb = bus.addr[1:0];

    sram_bank #(.AW(MEM_AW)) u_bank (
        .clk     (clk),
        .en_i    (mem_en),
        .we_i    (bus.wen),
        .addr_i  (bus.addr[MEM_AW+1:2]),
        .wdata_i (bus.wdata),
        .rdata_o (mem_rdata)
    );

`ifdef TIMER_EN
    logic [31:0] timer_q, timer_d;

    // Written bytes override, unwritten bytes still advance with the count.
    always_comb begin
        timer_d = timer_q + 32'd1;
        if (reg_acc && offset == OFF_TIMER) begin
            timer_d = merge_bytes(timer_q + 32'd1, bus.wdata, bus.wen);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
    end
`endif

    always_comb begin
        case (offset)
            OFF_LED:    reg_rd = {16'h0000, led_q};
            OFF_NUM:    reg_rd = num_q;
            OFF_SWITCH: reg_rd = 32'(switch_in);
`ifdef TIMER_EN
            OFF_TIMER:  reg_rd = timer_q;
`endif
            OFF_SIMU:   reg_rd = SIMU_FLAG;
            default:    reg_rd = '0;
        endcase
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        src_d       = src_q;
        reg_rdata_d = reg_rdata_q;
        led_d       = led_q;
        num_d       = num_q;
        if (bus.en) begin
            src_d = is_reg ? SRC_REG : SRC_MEM;
        end
        if (reg_acc) begin
            reg_rdata_d = reg_rd;
            if (offset == OFF_LED) begin
                led_d = {bus.wen[1] ? bus.wdata[15:8] : led_q[15:8],
                         bus.wen[0] ? bus.wdata[7:0]  : led_q[7:0]};
            end
            if (offset == OFF_NUM) begin
                num_d = merge_bytes(num_q, bus.wdata, bus.wen);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q       <= SRC_NONE;
            reg_rdata_q <= '0;
            led_q       <= '0;
            num_q       <= '0;
        end else begin
            src_q       <= src_d;
            reg_rdata_q <= reg_rdata_d;
            led_q       <= led_d;
            num_q       <= num_d;
        end
    end

    assign bus.rdata = (src_q == SRC_MEM) ? mem_rdata   :
                       (src_q == SRC_REG) ? reg_rdata_q : 32'h0;
    assign led       = led_q;
    assign num_data  = num_q;

endmodule
